// File: rtl/sd_sector_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : sd_sector_buffer
//  Description : Captures one SD block into a 512x8 RAM with a running
//                checksum, then replays it over a valid/ready byte stream.
//  Revision    : 1.0  initial release
// ============================================================================
module sd_sector_buffer #(
    parameter int DEPTH = 512,
    parameter int CW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    wr_data,
    input  logic          wr_valid,
    input  logic          blk_done,
    input  logic          clear,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          rd_last,
    output logic [CW-1:0] byte_count,
    output logic [15:0]   checksum,
    output logic          full,
    output logic          overflow,
    output logic          drain_done
);

    localparam int          c_AW    = $clog2(DEPTH);
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_FETCH = 2'd1,
        S_SHOW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_wv_q;
    logic            r_bd_q;
    logic            r_wv_arm;
    logic            r_bd_arm;
    logic [CW-1:0]   r_byte_count;
    logic [15:0]     r_checksum;
    logic [CW-1:0]   r_rd_ptr;
    logic            r_overflow;
    logic [7:0]      r_rd_data;
    logic [7:0]      r_mem [DEPTH];

    logic            w_wr_edge;
    logic            w_bd_edge;
    logic            w_full;
    logic            w_capture;
    logic            w_drop;
    logic            w_start;
    logic            w_accept;
    logic            w_last;

    // The arm flags ignore a level that was already high when reset released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wv_q   <= 1'b0;
            r_bd_q   <= 1'b0;
            r_wv_arm <= 1'b0;
            r_bd_arm <= 1'b0;
        end else begin
            r_wv_q   <= wr_valid;
            r_bd_q   <= blk_done;
            r_wv_arm <= r_wv_arm | ~wr_valid;
            r_bd_arm <= r_bd_arm | ~blk_done;
        end
    end

    assign w_wr_edge = wr_valid & ~r_wv_q & r_wv_arm;
    assign w_bd_edge = blk_done & ~r_bd_q & r_bd_arm;
    assign w_full    = (r_byte_count == c_DEPTH);
    assign w_capture = (r_state == S_FILL) & w_wr_edge & ~w_full & ~clear;
    assign w_drop    = w_wr_edge & ~((r_state == S_FILL) & ~w_full);
    // A byte arriving with the end-of-block edge is counted before leaving FILL.
    assign w_start   = (r_state == S_FILL) & w_bd_edge
                     & ((r_byte_count != '0) | w_capture);
    assign w_accept  = (r_state == S_SHOW) & rd_ready;
    assign w_last    = (r_rd_ptr == r_byte_count - CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FILL:  if (w_start) w_next = S_FETCH;
            S_FETCH: w_next = S_SHOW;
            S_SHOW:  if (w_accept) w_next = w_last ? S_DONE : S_FETCH;
            S_DONE:  w_next = S_FILL;
            default: w_next = S_FILL;
        endcase
        if (clear) begin
            w_next = S_FILL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_count <= '0;
            r_checksum   <= '0;
            r_rd_ptr     <= '0;
            r_overflow   <= 1'b0;
        end else if (clear) begin
            r_byte_count <= '0;
            r_checksum   <= '0;
            r_rd_ptr     <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_byte_count <= r_byte_count + CW'(1);
                r_checksum   <= r_checksum + {8'h00, wr_data};
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_start) begin
                r_rd_ptr <= '0;
            end
            if (w_accept && !w_last) begin
                r_rd_ptr <= r_rd_ptr + CW'(1);
            end
            if (r_state == S_DONE) begin
                r_byte_count <= '0;
                r_checksum   <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem[r_byte_count[c_AW-1:0]] <= wr_data;
        end
    end

    // Read register only loads in FETCH, so the byte holds through SHOW stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= 8'h00;
        end else if (r_state == S_FETCH) begin
            r_rd_data <= r_mem[r_rd_ptr[c_AW-1:0]];
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = (r_state == S_SHOW);
    assign rd_last    = (r_state == S_SHOW) & w_last;
    assign byte_count = r_byte_count;
    assign checksum   = r_checksum;
    assign full       = w_full;
    assign overflow   = r_overflow;
    assign drain_done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sd_sector_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_sector_buffer
//  Description : Scoreboard bench for sd_sector_buffer capture and replay.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sd_sector_buffer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        blk_done;
    logic        clear;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        rd_last;
    logic [9:0]  byte_count;
    logic [15:0] checksum;
    logic        full;
    logic        overflow;
    logic        drain_done;

    int n_checks   = 0;
    int n_fails    = 0;
    int n_drain    = 0;
    int n_accepted = 0;

    // Expected replay bytes: {last, data}
    logic [8:0] exp_q[$];
    bit         pending_drain = 0;
    bit         held          = 0;
    logic [7:0] held_data     = 8'h00;

    sd_sector_buffer #(.DEPTH(512), .CW(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .blk_done   (blk_done),
        .clear      (clear),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_last    (rd_last),
        .byte_count (byte_count),
        .checksum   (checksum),
        .full       (full),
        .overflow   (overflow),
        .drain_done (drain_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid && held) begin
                chk("rd_stable", rd_data, held_data);
            end
            held = 0;
            if (pending_drain) begin
                chk("drain_done", drain_done, 1);
                if (drain_done) n_drain++;
                pending_drain = 0;
            end else if (drain_done) begin
                n_checks++;
                n_fails++;
                $display("FAIL drain_spurious: got 1 expected 0 at %0t", $time);
            end
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL extra_byte: got %0h expected none at %0t", rd_data, $time);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("rd_data", rd_data, e[7:0]);
                    chk("rd_last", rd_last, e[8]);
                    n_accepted++;
                    if (rd_last) pending_drain = 1;
                end
            end else if (rd_valid) begin
                held      = 1;
                held_data = rd_data;
            end
        end else begin
            held          = 0;
            pending_drain = 0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold);
        wr_data  = b;
        wr_valid = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        wr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic start_replay();
        blk_done = 1'b1;
        @(posedge clk);
        #1;
        chk("fetch_gap_valid", rd_valid, 0);
        @(posedge clk);
        #1;
        chk("first_valid", rd_valid, 1);
        blk_done = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input bit rnd);
        int d0;
        int k;
        d0 = n_drain;
        k  = 0;
        while (n_drain == d0 && k < budget) begin
            @(posedge clk);
            #1;
            if (rnd) rd_ready = 1'($urandom_range(0, 1));
            k++;
        end
        chk("drain_seen", (n_drain > d0), 1);
        chk("queue_empty", exp_q.size(), 0);
        chk("count_cleared", byte_count, 0);
        chk("checksum_cleared", checksum, 0);
        rd_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        wr_data  = 8'h00;
        wr_valid = 1'b0;
        blk_done = 1'b0;
        clear    = 1'b0;
        rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_count", byte_count, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drain", drain_done, 0);
        @(posedge clk);
        #1;

        // Full sector of 0x00..0xFF twice
        for (int i = 0; i < 512; i++) begin
            send_byte(8'(i), 8);
            exp_q.push_back({(i == 511), 8'(i)});
        end
        chk("t1_count", byte_count, 512);
        chk("t1_full", full, 1);
        chk("t1_checksum", checksum, 16'hFF00);
        chk("t1_overflow", overflow, 0);
        rd_ready = 1'b1;
        start_replay();
        wait_drain(3000, 0);

        // 513 bytes: last one dropped
        for (int i = 0; i < 513; i++) begin
            send_byte((i == 512) ? 8'hEE : 8'(i), 2);
            if (i < 512) exp_q.push_back({(i == 511), 8'(i)});
        end
        chk("t2_count", byte_count, 512);
        chk("t2_full", full, 1);
        chk("t2_overflow", overflow, 1);
        chk("t2_checksum", checksum, 16'hFF00);
        start_replay();
        wait_drain(3000, 0);
        chk("t2_overflow_sticky", overflow, 1);

        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clear_overflow", overflow, 0);

        // Three bytes with random backpressure
        send_byte(8'hA5, 3);
        send_byte(8'h5A, 3);
        send_byte(8'hFF, 3);
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, 8'h5A});
        exp_q.push_back({1'b1, 8'hFF});
        chk("t3_checksum", checksum, 16'h01FE);
        chk("t3_count", byte_count, 3);
        begin
            int d0;
            d0 = n_drain;
            rd_ready = 1'b0;
            start_replay();
            wait_drain(500, 1);
            repeat (3) @(posedge clk);
            #1;
            chk("t3_drain_once", n_drain - d0, 1);
        end

        // End-of-block with nothing captured
        blk_done = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t4_empty_no_valid", rd_valid, 0);
        blk_done = 1'b0;
        @(posedge clk);
        #1;

        // Byte arriving during SHOW is dropped
        send_byte(8'h11, 2);
        send_byte(8'h22, 2);
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h22});
        rd_ready = 1'b0;
        start_replay();
        send_byte(8'h99, 3);
        chk("t4_show_overflow", overflow, 1);
        chk("t4_show_count", byte_count, 2);
        rd_ready = 1'b1;
        wait_drain(200, 0);

        // clear during replay at byte 100
        for (int i = 0; i < 150; i++) begin
            send_byte(8'(i * 3), 2);
            exp_q.push_back({(i == 149), 8'(i * 3)});
        end
        n_accepted = 0;
        rd_ready = 1'b1;
        start_replay();
        for (int k = 0; k < 400 && n_accepted < 100; k++) begin
            @(posedge clk);
            #1;
        end
        chk("t5_accepted", n_accepted, 100);
        rd_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_show_100", rd_valid, 1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        exp_q.delete();
        chk("t5_valid_dropped", rd_valid, 0);
        chk("t5_count", byte_count, 0);
        chk("t5_overflow", overflow, 0);
        send_byte(8'h01, 2);
        send_byte(8'h80, 2);
        send_byte(8'hC3, 2);
        send_byte(8'h7E, 2);
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h80});
        exp_q.push_back({1'b0, 8'hC3});
        exp_q.push_back({1'b1, 8'h7E});
        chk("t5_new_count", byte_count, 4);
        chk("t5_new_checksum", checksum, 16'h01C2);
        rd_ready = 1'b1;
        start_replay();
        wait_drain(100, 0);

        // Reset mid-fill with wr_valid held high
        send_byte(8'h10, 2);
        send_byte(8'h20, 2);
        wr_data  = 8'h55;
        wr_valid = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_count", byte_count, 0);
        chk("t6_checksum", checksum, 0);
        chk("t6_rd_valid", rd_valid, 0);
        chk("t6_rd_data", rd_data, 0);
        chk("t6_rd_last", rd_last, 0);
        chk("t6_full", full, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_drain", drain_done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_no_capture_held", byte_count, 0);
        wr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send_byte(8'h42, 3);
        chk("t6_recapture_count", byte_count, 1);
        chk("t6_recapture_sum", checksum, 16'h0042);
        exp_q.push_back({1'b1, 8'h42});
        start_replay();
        wait_drain(100, 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
